// File: rtl/minn_running_sum_mc.sv
// Multi-channel sliding-window accumulator for the Minn timing metric.
// Each channel keeps the exact sum of its last len_q accepted samples; len_q is captured on restart.
module minn_running_sum_mc #(
    parameter int WIDTH     = 16,
    parameter int MAX_DEPTH = 64,
    parameter int CHANNELS  = 2,
    localparam int LEN_W    = $clog2(MAX_DEPTH + 1),
    localparam int SUM_W    = WIDTH + LEN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic [LEN_W-1:0]          win_len,
    input  logic                      restart,
    output logic [CHANNELS*SUM_W-1:0] sum_out,
    output logic                      sum_valid,
    output logic [LEN_W-1:0]          fill_level,
    output logic                      cfg_err
);

    localparam int PTR_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t                      r_state, w_state_nxt;
    logic [CHANNELS*WIDTH-1:0]   r_mem [MAX_DEPTH];
    logic [PTR_W-1:0]            r_wptr;
    logic [LEN_W-1:0]            r_len_q;
    logic [LEN_W-1:0]            r_fill;
    logic [CHANNELS*SUM_W-1:0]   r_sum;
    logic                        r_sum_valid;
    logic                        r_cfg_err;

    logic                        w_len_ok;
    logic [LEN_W-1:0]            w_len_new;
    logic                        w_len_one;
    logic                        w_wrap;
    logic                        w_fill_done;
    logic [PTR_W-1:0]            w_waddr;
    logic [CHANNELS*WIDTH-1:0]   w_old_row;
    logic [SUM_W-1:0]            w_new_ext;
    logic [SUM_W-1:0]            w_old_ext;
    logic [CHANNELS*SUM_W-1:0]   w_sum_acc;
    logic [CHANNELS*SUM_W-1:0]   w_sum_first;

    always_comb begin
        w_len_ok    = (win_len != '0) && (win_len <= LEN_W'(MAX_DEPTH));
        w_len_new   = w_len_ok ? win_len : LEN_W'(MAX_DEPTH);
        w_len_one   = (w_len_new == LEN_W'(1));
        w_wrap      = (LEN_W'(r_wptr) == (r_len_q - LEN_W'(1)));
        w_fill_done = ((r_fill + LEN_W'(1)) == r_len_q);
        w_waddr     = restart ? '0 : r_wptr;
        // While filling, the slot under the pointer holds stale data and must not be subtracted
        w_old_row   = (r_state == S_RUN) ? r_mem[r_wptr] : '0;
        w_new_ext   = '0;
        w_old_ext   = '0;
        w_sum_acc   = '0;
        w_sum_first = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_new_ext = {{(SUM_W-WIDTH){sample_in[c*WIDTH + WIDTH - 1]}}, sample_in[c*WIDTH +: WIDTH]};
            w_old_ext = {{(SUM_W-WIDTH){w_old_row[c*WIDTH + WIDTH - 1]}}, w_old_row[c*WIDTH +: WIDTH]};
            w_sum_acc[c*SUM_W +: SUM_W]   = r_sum[c*SUM_W +: SUM_W] + w_new_ext - w_old_ext;
            w_sum_first[c*SUM_W +: SUM_W] = w_new_ext;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = (in_valid && w_len_one) ? S_RUN : S_FILL;
        end else if (in_valid && (r_state == S_FILL) && w_fill_done) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_len_q     <= LEN_W'(MAX_DEPTH);
            r_fill      <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= restart && !w_len_ok;
            if (restart) begin
                r_len_q <= w_len_new;
                if (in_valid) begin
                    r_sum       <= w_sum_first;
                    r_fill      <= LEN_W'(1);
                    r_sum_valid <= w_len_one;
                    r_wptr      <= w_len_one ? '0 : PTR_W'(1);
                end else begin
                    r_sum       <= '0;
                    r_fill      <= '0;
                    r_sum_valid <= 1'b0;
                    r_wptr      <= '0;
                end
            end else if (in_valid) begin
                r_sum  <= w_sum_acc;
                r_wptr <= w_wrap ? '0 : (r_wptr + PTR_W'(1));
                if (r_state == S_FILL) begin
                    r_fill <= r_fill + LEN_W'(1);
                    if (w_fill_done) begin
                        r_sum_valid <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_mem[w_waddr] <= sample_in;
        end
    end

    assign sum_out    = r_sum;
    assign sum_valid  = r_sum_valid;
    assign fill_level = r_fill;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_minn_running_sum_mc.sv
// Scoreboard bench for minn_running_sum_mc: driver queues hand-computed expectations, monitor checks each edge.
module tb_minn_running_sum_mc;

    localparam int WIDTH     = 16;
    localparam int MAX_DEPTH = 64;
    localparam int CHANNELS  = 2;
    localparam int LEN_W     = $clog2(MAX_DEPTH + 1);
    localparam int SUM_W     = WIDTH + LEN_W;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic [LEN_W-1:0]          win_len;
    logic                      restart;
    logic [CHANNELS*SUM_W-1:0] sum_out;
    logic                      sum_valid;
    logic [LEN_W-1:0]          fill_level;
    logic                      cfg_err;

    typedef struct {
        int    s0;
        int    s1;
        int    v;
        int    f;
        int    c;
        string nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    minn_running_sum_mc #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH),
        .CHANNELS  (CHANNELS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sample_in  (sample_in),
        .win_len    (win_len),
        .restart    (restart),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid),
        .fill_level (fill_level),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int ch_sum(input int c);
        logic signed [SUM_W-1:0] s;
        s = sum_out[c*SUM_W +: SUM_W];
        return int'(s);
    endfunction

    // Monitor: one expectation per clock edge once the driver is running
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && q.size() > 0) begin
                #1;
                e = q.pop_front();
                chk({e.nm, ".sum0"}, ch_sum(0), e.s0);
                chk({e.nm, ".sum1"}, ch_sum(1), e.s1);
                chk({e.nm, ".valid"}, int'(sum_valid), e.v);
                chk({e.nm, ".fill"}, int'(fill_level), e.f);
                chk({e.nm, ".cfg_err"}, int'(cfg_err), e.c);
            end
        end
    end

    task automatic step(input bit v, input bit rs, input int s0, input int s1,
                        input int e0, input int e1, input int ev, input int ef,
                        input int ec, input string nm);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        restart   = rs;
        sample_in = {WIDTH'(s1), WIDTH'(s0)};
        e.s0 = e0; e.s1 = e1; e.v = ev; e.f = ef; e.c = ec; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        restart   = 1'b0;
        sample_in = {WIDTH'(123), WIDTH'(-45)};
        win_len   = LEN_W'(4);

        // T1: reset held with in_valid active
        repeat (3) @(posedge clk);
        #1;
        chk("rst.sum", int'(sum_out != '0), 0);
        chk("rst.valid", int'(sum_valid), 0);
        chk("rst.fill", int'(fill_level), 0);
        chk("rst.cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // T2: win_len=4 ramp
        win_len = LEN_W'(4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t2.restart");
        step(1, 0, 1, -1, 1, -1, 0, 1, 0, "t2.s1");
        step(1, 0, 2, -2, 3, -3, 0, 2, 0, "t2.s2");
        step(1, 0, 3, -3, 6, -6, 0, 3, 0, "t2.s3");
        step(1, 0, 4, -4, 10, -10, 1, 4, 0, "t2.s4");
        step(1, 0, 5, -5, 14, -14, 1, 4, 0, "t2.s5");

        // T3: gaps hold outputs; win_len change without restart ignored
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t3.restart");
        step(1, 0, 10, 100, 10, 100, 0, 1, 0, "t3.s1");
        step(0, 0, 99, 99, 10, 100, 0, 1, 0, "t3.gap1");
        step(1, 0, 20, 200, 30, 300, 0, 2, 0, "t3.s2");
        step(0, 0, 77, 77, 30, 300, 0, 2, 0, "t3.gap2");
        step(0, 0, 77, 77, 30, 300, 0, 2, 0, "t3.gap3");
        step(1, 0, 30, 300, 60, 600, 0, 3, 0, "t3.s3");
        step(1, 0, 40, 400, 100, 1000, 1, 4, 0, "t3.s4");
        win_len = LEN_W'(2);
        step(0, 0, 1, 1, 100, 1000, 1, 4, 0, "t3.gap4");
        step(1, 0, 50, 500, 140, 1400, 1, 4, 0, "t3.s5");
        step(0, 0, 1, 1, 140, 1400, 1, 4, 0, "t3.gap5");
        step(1, 0, 60, 600, 180, 1800, 1, 4, 0, "t3.s6");
        step(1, 0, -70, -700, 80, 800, 1, 4, 0, "t3.s7");

        // T5: restart coincident with a sample, win_len=2
        win_len = LEN_W'(2);
        step(1, 1, 7, -7, 7, -7, 0, 1, 0, "t5.rs7");
        step(1, 0, 3, -3, 10, -10, 1, 2, 0, "t5.s3");
        step(1, 0, 5, -5, 8, -8, 1, 2, 0, "t5.s5");
        step(1, 0, 1, -1, 6, -6, 1, 2, 0, "t5.s1");

        // len_q==1: output tracks the latest sample
        win_len = LEN_W'(1);
        step(1, 1, 9, -9, 9, -9, 1, 1, 0, "l1.rs9");
        step(1, 0, 4, -4, 4, -4, 1, 1, 0, "l1.s4");
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "l1.restart");
        step(1, 0, 5, -5, 5, -5, 1, 1, 0, "l1.s5");
        step(1, 0, -3, 3, -3, 3, 1, 1, 0, "l1.sm3");

        // T4: extremes over a 64-deep window
        win_len = LEN_W'(64);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t4.restart");
        for (int k = 1; k <= 64; k++) begin
            step(1, 0, -32768, 32767, -32768 * k, 32767 * k,
                 (k == 64) ? 1 : 0, k, 0, $sformatf("t4.a%0d", k));
        end
        for (int j = 1; j <= 64; j++) begin
            step(1, 0, 32767, -32768, -32768 * (64 - j) + 32767 * j,
                 32767 * (64 - j) - 32768 * j, 1, 64, 0, $sformatf("t4.b%0d", j));
        end

        // T6: out-of-range lengths fall back to MAX_DEPTH with a one-cycle error pulse
        win_len = LEN_W'(0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, "t6.len0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6.len0_after");
        win_len = LEN_W'(65);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, "t6.len65");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6.len65_after");
        for (int k = 1; k <= 64; k++) begin
            step(1, 0, 1, 2, k, 2 * k, (k == 64) ? 1 : 0, k, 0, $sformatf("t6.s%0d", k));
        end
        step(1, 0, 3, 5, 66, 131, 1, 64, 0, "t6.slide");

        // Async reset mid-window
        win_len = LEN_W'(4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "ar.restart");
        step(1, 0, 1, 2, 1, 2, 0, 1, 0, "ar.s1");
        step(1, 0, 3, 4, 4, 6, 0, 2, 0, "ar.s2");
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.sum", int'(sum_out != '0), 0);
        chk("arst.valid", int'(sum_valid), 0);
        chk("arst.fill", int'(fill_level), 0);
        chk("arst.cfg_err", int'(cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 5, 6, 5, 6, 0, 1, 0, "arst.post1");
        step(0, 0, 0, 0, 5, 6, 0, 1, 0, "arst.hold");

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard.drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
